ext_mem_loader: RTL and testbench
=================================

EXT_MEM_LOADER -- requirements
Module: ext_mem_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 128, number of 32-bit words loadable into instruction memory.
REQ-002 Parameter DMEM_WORDS, default 128, number of 64-bit words dumped from data memory.
REQ-003 Parameter CNT_W, default 16, width of the run-cycle counter.
REQ-004 One clock; reset is asynchronous and active-low: clk input 1, the single clock; arst_n input 1, the reset.
REQ-005 start input 1: one-cycle request to begin load/run/dump; ignored unless the FSM is in IDLE or DONE.
REQ-006 run_cycles input CNT_W: number of cycles cpu_enable is held high; sampled on an accepted start.
REQ-007 prog_valid input 1, prog_ready output 1, prog_data input 32, prog_last input 1: program word stream.
REQ-008 dump_valid output 1, dump_ready input 1, dump_data output 64, dump_last output 1: data-memory dump stream.
REQ-009 busy output 1 (FSM not IDLE/DONE); done output 1 (FSM in DONE); cpu_enable output 1, drives the CPU enable.
REQ-010 addr_ext output 64, wen_ext output 1, ren_ext output 1, wdata_ext output 32: instruction-memory external port.
REQ-011 addr_ext_2 output 64, wen_ext_2 output 1, ren_ext_2 output 1, wdata_ext_2 output 64, rdata_ext_2 input 64: data-memory external port.

Function
REQ-012 FSM states: IDLE, LOAD, RUN, RD_REQ, RD_WAIT, OUT, DONE.
REQ-013 IDLE/DONE + start -> LOAD; clear word index; latch run_cycles; DONE is left only on start.
REQ-014 LOAD: prog_ready=1; a word transfers when prog_valid&&prog_ready; in that same cycle wen_ext=1, wdata_ext=prog_data, addr_ext=4*index (byte address).
REQ-015 LOAD exits to RUN after the transfer carrying prog_last=1, or after transfer number IMEM_WORDS, whichever comes first; prog_ready is 0 in every state other than LOAD.
REQ-016 RUN: cpu_enable=1 for exactly the latched run_cycles cycles, then RD_REQ; if run_cycles=0, RUN lasts 0 cycles (LOAD goes directly to RD_REQ).
REQ-017 RD_REQ: ren_ext_2=1 for one cycle, addr_ext_2=8*dump index; next state RD_WAIT.
REQ-018 RD_WAIT: capture rdata_ext_2 (one-cycle read latency) into dump_data; next state OUT.
REQ-019 OUT: dump_valid=1; dump_data and dump_last are held stable until dump_ready=1; dump_last=1 only on index DMEM_WORDS-1.
REQ-020 On handshake in OUT: if last, go to DONE; else increment index and go to RD_REQ; a new read is never issued while a word is pending.
REQ-021 wen_ext_2, ren_ext, and wdata_ext_2 are constant 0; the memory ext ports are never driven while cpu_enable=1.
REQ-022 Index/cycle counters never wrap: the index saturates at its final value, and the cycle counter is compared for equality, never allowed to overflow.
REQ-023 Every output is registered or a pure decode of the state register; there is no combinational path from any input to any output, except prog_ready, which has no input dependence.

Reset
REQ-024 arst_n low at any time, including mid-LOAD/RUN/dump: state=IDLE, counters=0, and every output=0 (cpu_enable, wen_ext, ren_ext_2, prog_ready, dump_valid, dump_last, busy, done, all address/data outputs).
REQ-025 After reset release, no port activity occurs until start.

Structure
REQ-026 A shared package holds the FSM state enum and the byte strides (4 for IMEM, 8 for DMEM).
REQ-027 Counters use the existing reg_arstn_en register sub-module where practical; no other sub-module is required.

Verification
REQ-028 Load 3 words 0x00500093,0x00A00113,0x002081B3 with prog_last on the third -> three wen_ext pulses at addresses 0,4,8, then RUN.
REQ-029 IMEM_WORDS=4, stream 6 words without prog_last -> 4 writes, then prog_ready=0, and the FSM proceeds to RUN.
REQ-030 run_cycles=10 -> cpu_enable is high for exactly 10 cycles; with run_cycles=0 -> cpu_enable is never high.
REQ-031 DMEM_WORDS=4, memory preloaded with 1,2,3,4, dump_ready toggling 1010 -> dump_data sequence 1,2,3,4, held stable under stall, dump_last on the 4th word, then done=1.
REQ-032 arst_n asserted in the middle of RUN and in OUT -> all outputs 0 in the same cycle; a following start performs a full, correct sequence.
REQ-033 start while busy -> ignored, with no change of state, counters, or latched run_cycles.

Source files
------------

// File: rtl/ext_mem_loader_pkg.sv
// ext_mem_loader_pkg: FSM states and memory byte strides shared by the loader.
package ext_mem_loader_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        RD_REQ,
        RD_WAIT,
        OUT,
        DONE
    } state_t;
    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;
endpackage

// File: rtl/ext_mem_loader_if.sv
// ext_mem_loader_if: program/dump streams and the two external memory ports.
interface ext_mem_loader_if;
    logic        prog_valid;
    logic        prog_ready;
    logic [31:0] prog_data;
    logic        prog_last;
    logic        dump_valid;
    logic        dump_ready;
    logic [63:0] dump_data;
    logic        dump_last;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;
    modport master (
        input  prog_valid, prog_data, prog_last, dump_ready, rdata_ext_2,
        output prog_ready, dump_valid, dump_data, dump_last,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
    modport slave (
        output prog_valid, prog_data, prog_last, dump_ready, rdata_ext_2,
        input  prog_ready, dump_valid, dump_data, dump_last,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/reg_arstn_en.sv
// reg_arstn_en: enabled register with asynchronous active-low clear.
module reg_arstn_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/ext_mem_loader.sv
// ext_mem_loader: streams a program into IMEM, runs the CPU for a set number of
// cycles, then dumps DMEM out over a valid/ready stream.
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] run_cycles,
    output logic             busy,
    output logic             done,
    output logic             cpu_enable,
    ext_mem_loader_if.master bus
);
    localparam int IW = IMEM_WORDS > 1 ? $clog2(IMEM_WORDS) : 1;
    localparam int DW = DMEM_WORDS > 1 ? $clog2(DMEM_WORDS) : 1;

    state_t           state_q, state_d;
    logic [IW-1:0]    iidx_q;
    logic [DW-1:0]    didx_q;
    logic [CNT_W-1:0] cyc_q, run_q;
    logic             fin_q, wen_q;
    logic [63:0]      waddr_q, ddata_q;
    logic [31:0]      wdata_q;

    logic acc, xfer, ilast, dlast, hs;
    assign acc   = start && (state_q == IDLE || state_q == DONE);
    assign xfer  = bus.prog_ready && bus.prog_valid;
    assign ilast = xfer && (bus.prog_last || iidx_q == IW'(IMEM_WORDS - 1));
    assign dlast = didx_q == DW'(DMEM_WORDS - 1);
    assign hs    = state_q == OUT && bus.dump_ready;

    reg_arstn_en #(.W(IW)) u_iidx (
        .clk(clk), .arst_n(arst_n), .en(acc || (xfer && !ilast)),
        .d(acc ? '0 : iidx_q + IW'(1)), .q(iidx_q)
    );
    reg_arstn_en #(.W(1)) u_fin (
        .clk(clk), .arst_n(arst_n), .en(acc || ilast), .d(!acc), .q(fin_q)
    );
    reg_arstn_en #(.W(CNT_W)) u_run (
        .clk(clk), .arst_n(arst_n), .en(acc), .d(run_cycles), .q(run_q)
    );
    reg_arstn_en #(.W(CNT_W)) u_cyc (
        .clk(clk), .arst_n(arst_n), .en(acc || state_q == RUN),
        .d(acc ? '0 : cyc_q + CNT_W'(1)), .q(cyc_q)
    );
    reg_arstn_en #(.W(DW)) u_didx (
        .clk(clk), .arst_n(arst_n), .en(acc || (hs && !dlast)),
        .d(acc ? '0 : didx_q + DW'(1)), .q(didx_q)
    );

    // LOAD lingers one cycle after the final transfer so the registered write
    // pulse lands before cpu_enable rises.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? LOAD : state_q;
            LOAD:       state_d = !fin_q ? LOAD : (run_q == '0 ? RD_REQ : RUN);
            RUN:        state_d = cyc_q == run_q - CNT_W'(1) ? RD_REQ : RUN;
            RD_REQ:     state_d = RD_WAIT;
            RD_WAIT:    state_d = OUT;
            OUT:        state_d = !bus.dump_ready ? OUT : (dlast ? DONE : RD_REQ);
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ddata_q <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= xfer;
            waddr_q <= xfer ? 64'(iidx_q) * 64'(IMEM_STRIDE) : '0;
            wdata_q <= xfer ? bus.prog_data : '0;
            if (state_q == RD_WAIT) ddata_q <= bus.rdata_ext_2;
        end
    end

    assign busy            = !(state_q == IDLE || state_q == DONE);
    assign done            = state_q == DONE;
    assign cpu_enable      = state_q == RUN;
    assign bus.prog_ready  = state_q == LOAD && !fin_q;
    assign bus.wen_ext     = wen_q;
    assign bus.addr_ext    = waddr_q;
    assign bus.wdata_ext   = wdata_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.ren_ext_2   = state_q == RD_REQ;
    assign bus.addr_ext_2  = state_q == RD_REQ ? 64'(didx_q) * 64'(DMEM_STRIDE) : '0;
    assign bus.wen_ext_2   = 1'b0;
    assign bus.wdata_ext_2 = '0;
    assign bus.dump_valid  = state_q == OUT;
    assign bus.dump_last   = state_q == OUT && dlast;
    assign bus.dump_data   = ddata_q;
endmodule

// File: tb/tb_ext_mem_loader.sv
// tb_ext_mem_loader: directed scenarios for the loader with IMEM/DMEM of 4 words.
module tb_ext_mem_loader;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] run_cycles = '0;
    logic        busy, done, cpu_enable;
    int          checks = 0, passed = 0;

    ext_mem_loader_if bus ();

    ext_mem_loader #(.IMEM_WORDS(4), .DMEM_WORDS(4), .CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .run_cycles(run_cycles),
        .busy(busy), .done(done), .cpu_enable(cpu_enable), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [297:0] outs;
    assign outs = {busy, done, cpu_enable, bus.prog_ready, bus.wen_ext, bus.ren_ext,
                   bus.ren_ext_2, bus.wen_ext_2, bus.dump_valid, bus.dump_last,
                   bus.addr_ext, bus.addr_ext_2, bus.wdata_ext, bus.wdata_ext_2,
                   bus.dump_data};

    logic [31:0] words [6];
    logic [63:0] dmem [4];

    // DMEM model with one-cycle read latency
    always @(posedge clk)
        if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[4:3]];

    logic [63:0] wa [$];
    logic [31:0] wd [$];
    logic [63:0] dd [$];
    logic        dl [$];
    int          en_cnt = 0, viol = 0, stalls = 0, stall_bad = 0;
    logic        hold_v = 1'b0, hold_l = 1'b0;
    logic [63:0] hold_d = '0;

    always @(negedge clk) begin
        if (bus.wen_ext) begin
            wa.push_back(bus.addr_ext);
            wd.push_back(bus.wdata_ext);
        end
        if (cpu_enable) en_cnt++;
        if (cpu_enable && (bus.wen_ext || bus.ren_ext || bus.ren_ext_2 || bus.wen_ext_2)) viol++;
        if (bus.dump_valid && bus.dump_ready) begin
            dd.push_back(bus.dump_data);
            dl.push_back(bus.dump_last);
        end
        if (arst_n && hold_v && (!bus.dump_valid || bus.dump_data !== hold_d || bus.dump_last !== hold_l))
            stall_bad++;
        if (bus.dump_valid && !bus.dump_ready) stalls++;
        hold_v = arst_n && bus.dump_valid && !bus.dump_ready;
        hold_d = bus.dump_data;
        hold_l = bus.dump_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] rc);
        run_cycles = rc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int n, input int last_idx, output int acc);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            bus.prog_valid = 1'b1;
            bus.prog_data  = words[i];
            bus.prog_last  = (i == last_idx);
            for (int k = 0; k < 4 && !bus.prog_ready; k++) tick();
            if (!bus.prog_ready) break;
            tick();
            acc++;
        end
        bus.prog_valid = 1'b0;
        bus.prog_last  = 1'b0;
        bus.prog_data  = '0;
    endtask

    task automatic wait_done(input bit toggle);
        bus.dump_ready = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            bus.dump_ready = toggle ? !bus.dump_ready : 1'b1;
        end
        bus.dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (outs !== '0) $display("FAIL reset_outs: got %h want 0", outs); else passed++;
        arst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (outs !== '0) $display("FAIL idle_quiet: got %h want 0", outs); else passed++;
    endtask

    task automatic test_load3();
        int w0, e0, d0, acc;
        w0 = wa.size(); e0 = en_cnt; d0 = dd.size();
        pulse_start(16'd3);
        stream(3, 2, acc);
        checks++;
        if (acc != 3) $display("FAIL load3_accepted: got %0d want 3", acc); else passed++;
        checks++;
        if (bus.prog_ready !== 1'b0) $display("FAIL load3_ready_low: got %b want 0", bus.prog_ready); else passed++;
        tick();
        checks++;
        if (cpu_enable !== 1'b1) $display("FAIL load3_run: got %b want 1", cpu_enable); else passed++;
        checks++;
        if (wa.size() - w0 != 3) $display("FAIL load3_writes: got %0d want 3", wa.size() - w0);
        else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa[w0+i] !== 64'(4 * i) || wd[w0+i] !== words[i])
                    $display("FAIL load3_word%0d: got %h@%h want %h@%h", i, wd[w0+i], wa[w0+i], words[i], 4 * i);
                else passed++;
            end
        end
        wait_done(1'b0);
        checks++;
        if (done !== 1'b1) $display("FAIL load3_done: got %b want 1", done); else passed++;
        checks++;
        if (en_cnt - e0 != 3) $display("FAIL load3_cycles: got %0d want 3", en_cnt - e0); else passed++;
        checks++;
        if (dd.size() - d0 != 4) $display("FAIL load3_dumps: got %0d want 4", dd.size() - d0); else passed++;
    endtask

    task automatic test_imem_limit();
        int w0, acc;
        w0 = wa.size();
        pulse_start(16'd2);
        stream(6, -1, acc);
        checks++;
        if (acc != 4) $display("FAIL limit_accepted: got %0d want 4", acc); else passed++;
        checks++;
        if (bus.prog_ready !== 1'b0) $display("FAIL limit_ready_low: got %b want 0", bus.prog_ready); else passed++;
        checks++;
        if (wa.size() - w0 != 4) $display("FAIL limit_writes: got %0d want 4", wa.size() - w0);
        else begin
            passed++;
            checks++;
            if (wa[w0+3] !== 64'd12 || wd[w0+3] !== words[3])
                $display("FAIL limit_word3: got %h@%h want %h@c", wd[w0+3], wa[w0+3], words[3]);
            else passed++;
        end
        wait_done(1'b0);
        checks++;
        if (done !== 1'b1) $display("FAIL limit_done: got %b want 1", done); else passed++;
    endtask

    task automatic test_run_cycles();
        int e0, acc;
        e0 = en_cnt;
        pulse_start(16'd10);
        stream(1, 0, acc);
        wait_done(1'b0);
        checks++;
        if (en_cnt - e0 != 10) $display("FAIL run10_cycles: got %0d want 10", en_cnt - e0); else passed++;
        e0 = en_cnt;
        pulse_start(16'd0);
        stream(1, 0, acc);
        wait_done(1'b0);
        checks++;
        if (en_cnt - e0 != 0) $display("FAIL run0_cycles: got %0d want 0", en_cnt - e0); else passed++;
        checks++;
        if (done !== 1'b1) $display("FAIL run0_done: got %b want 1", done); else passed++;
    endtask

    task automatic test_dump_stall();
        int d0, s0, b0, acc;
        d0 = dd.size(); s0 = stalls; b0 = stall_bad;
        pulse_start(16'd1);
        stream(1, 0, acc);
        wait_done(1'b1);
        checks++;
        if (dd.size() - d0 != 4) $display("FAIL dump_count: got %0d want 4", dd.size() - d0);
        else begin
            passed++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dd[d0+i] !== 64'(i + 1) || dl[d0+i] !== (i == 3))
                    $display("FAIL dump_word%0d: got %h last %b want %h last %b", i, dd[d0+i], dl[d0+i], i + 1, i == 3);
                else passed++;
            end
        end
        checks++;
        if (stalls - s0 == 0) $display("FAIL dump_stalled: got 0 stall cycles want >0"); else passed++;
        checks++;
        if (stall_bad != b0) $display("FAIL dump_hold: got %0d unstable cycles want 0", stall_bad - b0); else passed++;
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL dump_done: got %b want 10", {done, busy}); else passed++;
    endtask

    task automatic test_reset_mid();
        int w0, e0, d0, acc;
        pulse_start(16'd50);
        stream(1, 0, acc);
        for (int k = 0; k < 10 && !cpu_enable; k++) tick();
        tick(); tick();
        checks++;
        if (cpu_enable !== 1'b1) $display("FAIL rst_run_reached: got %b want 1", cpu_enable); else passed++;
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) $display("FAIL rst_in_run: got %h want 0", outs); else passed++;
        tick();
        arst_n = 1'b1;
        tick();
        w0 = wa.size(); e0 = en_cnt; d0 = dd.size();
        pulse_start(16'd2);
        stream(3, 2, acc);
        wait_done(1'b0);
        checks++;
        if (wa.size() - w0 != 3 || en_cnt - e0 != 2 || dd.size() - d0 != 4)
            $display("FAIL rst_rerun: got w%0d c%0d d%0d want w3 c2 d4", wa.size() - w0, en_cnt - e0, dd.size() - d0);
        else passed++;
        pulse_start(16'd1);
        stream(1, 0, acc);
        for (int k = 0; k < 20 && !bus.dump_valid; k++) tick();
        checks++;
        if (bus.dump_valid !== 1'b1 || bus.dump_data !== 64'd1)
            $display("FAIL rst_out_reached: got v%b %h want v1 1", bus.dump_valid, bus.dump_data);
        else passed++;
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) $display("FAIL rst_in_out: got %h want 0", outs); else passed++;
        tick();
        arst_n = 1'b1;
        tick();
        d0 = dd.size();
        pulse_start(16'd1);
        stream(1, 0, acc);
        wait_done(1'b0);
        checks++;
        if (done !== 1'b1 || dd.size() - d0 != 4 || dd[dd.size()-1] !== 64'd4)
            $display("FAIL rst_out_rerun: got done %b d%0d want done 1 d4", done, dd.size() - d0);
        else passed++;
    endtask

    task automatic test_start_busy();
        int e0, d0, acc;
        logic [63:0] h;
        e0 = en_cnt; d0 = dd.size();
        pulse_start(16'd5);
        stream(1, 0, acc);
        tick();
        pulse_start(16'd99);
        checks++;
        if ({cpu_enable, bus.prog_ready, busy} !== 3'b101)
            $display("FAIL busy_start_run: got %b want 101", {cpu_enable, bus.prog_ready, busy});
        else passed++;
        for (int k = 0; k < 20 && !bus.dump_valid; k++) tick();
        h = bus.dump_data;
        pulse_start(16'd99);
        checks++;
        if ({bus.dump_valid, bus.prog_ready} !== 2'b10 || bus.dump_data !== h || h !== 64'd1)
            $display("FAIL busy_start_out: got v%b r%b %h want v1 r0 1", bus.dump_valid, bus.prog_ready, bus.dump_data);
        else passed++;
        wait_done(1'b0);
        checks++;
        if (en_cnt - e0 != 5 || dd.size() - d0 != 4)
            $display("FAIL busy_start_latch: got c%0d d%0d want c5 d4", en_cnt - e0, dd.size() - d0);
        else passed++;
    endtask

    initial begin
        words = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h11111111, 32'h22222222, 32'h33333333};
        dmem  = '{64'd1, 64'd2, 64'd3, 64'd4};
        bus.prog_valid = 1'b0;
        bus.prog_data  = '0;
        bus.prog_last  = 1'b0;
        bus.dump_ready = 1'b0;
        #1;
        test_reset();
        test_load3();
        test_imem_limit();
        test_run_cycles();
        test_dump_stall();
        test_reset_mid();
        test_start_busy();
        checks++;
        if (viol != 0) $display("FAIL port_during_run: got %0d cycles want 0", viol); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
